pipelined_prefix_adder: RTL
===========================

# pipelined_prefix_adder

Parametrised, pipelined parallel-prefix (Sklansky) adder/subtractor with valid/ready flow control on both sides. It generalises the team's 32-bit combinational prefix adder to any power-of-two width, a selectable number of pipeline register stages, an add/subtract mode and status flags. It is the arithmetic core for the multiplier's final carry-propagate stage and for the ALU datapath, and accepts one operation per cycle when not stalled.

## Interface
- WIDTH, 32, operand width; power of two, 8..64.
- PIPE, 2, register stages from accepted input to result; 1..log2(WIDTH)+1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept the bundle this cycle.
- in_x  in  WIDTH  operand X.
- in_y  in  WIDTH  operand Y.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  0: X+Y+cin; 1: X-Y (X + ~Y + 1).
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry out of bit WIDTH-1 (for subtract: 1 = no borrow).
- out_ovf  out  1  signed two's-complement overflow.
- out_zero  out  1  out_sum == 0.

## Operation
- Pre-processing: ye = in_sub ? ~in_y : in_y; c0 = in_sub ? 1 : in_cin; g = x&ye, p = x^ye.
- Prefix tree: log2(WIDTH) Sklansky levels of (G,P) combine; carry into bit i = G[i-1:0] including c0 as bit -1 generate.
- sum[i] = p[i] ^ carry[i]; cout = carry[WIDTH]; ovf = carry[WIDTH] ^ carry[WIDTH-1]; zero = ~|sum.
- Pipelining: PIPE register stages; stage k (1..PIPE) registers after prefix level round(k*L/PIPE), L = log2(WIDTH)+1 (pre-processing counts as a level); last stage always registers final sum and flags.
- Each stage holds a valid bit plus its partial (x, ye, c0, G, P, p) data; no combinational path from inputs to outputs.
- Stage k advances when stage k+1 can accept: adv[k] = ~valid[k] | adv[k+1]; adv[PIPE] = ~out_valid | out_ready; in_ready = adv[1].
- Bubbles collapse: an empty stage accepts even while a later stage is stalled.
- Transfer rules: input accepted on in_valid & in_ready; output consumed on out_valid & out_ready.
- Data registers load only on advance; stalled stages hold value unchanged.

## Timing
- Reset (rst_n=0, asynchronous): all stage valids 0; out_valid=0; out_sum=0, out_cout=0, out_ovf=0, out_zero=0. in_ready=1 immediately after reset release (all stages empty).
- Latency: bundle accepted at edge n appears with out_valid=1 after edge n+PIPE-1 (visible in cycle following edge n+PIPE-1; PIPE=1 means result registered at the accepting edge).
- Throughput: 1 bundle/cycle when out_ready held 1.
- Backpressure: out_valid=1 & out_ready=0 holds out_* stable; upstream fills; in_ready falls only when all PIPE stages are valid and out_ready=0.
- in_ready is combinational from out_ready (ready chain); out_* are purely registered.
- Simultaneous consume and accept with a full pipe: allowed, no bubble inserted.
- Reset mid-operation: all in-flight bundles discarded; nothing is emitted after reset release until new inputs are accepted.
- in_valid=0 cycles produce bubbles; out_valid follows valid bits exactly, never duplicated.

## Test plan
- Reset then WIDTH=32, PIPE=2: X=0xFFFFFFFF, Y=0x00000001, cin=0, add -> PIPE cycles later sum=0x00000000, cout=1, ovf=0, zero=1.
- Subtract: X=0x80000000, Y=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1, zero=0; X=5, Y=7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Carry-in chain: X=0x7FFFFFFF, Y=0, cin=1 -> sum=0x80000000, cout=0, ovf=1; with sub=1 same X,Y -> cin ignored, sum=0x7FFFFFFF.
- Backpressure: stream 8 bundles back-to-back, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops once PIPE stages full, out_sum stable while stalled, all 8 results in order, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 2 bundles in flight -> out_valid=0 and all outputs 0 immediately; no stale result after release.
- Parameter sweep WIDTH in {8,16,64}, PIPE in {1, log2(WIDTH)+1}: 10k random bundles with random in_valid/out_ready vs. reference model (X ± Y, flags) -> zero mismatches, latency exactly PIPE when unstalled.

Source files
------------

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Sklansky parallel-prefix adder/subtractor with valid/ready flow control.
// Pipeline registers sit between prefix levels. Each stage advances when it is
// empty or when the stage after it advances, so bubbles collapse under stall.
module pipelined_prefix_adder #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int LOG = $clog2(WIDTH);
  localparam int L   = LOG + 1;

  // g/pg: group generate/propagate so far; p: bit propagate kept for the sum.
  // c0 is folded into g[0], so after the last level g[i] is the carry into bit i+1.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] pg;
    logic [WIDTH-1:0] p;
    logic             c0;
  } lvl_t;

  // Stage k (1..PIPE-1) registers after prefix level round(k*L/PIPE)-1;
  // level index 0 is the output of pre-processing. Returns 0 if no register here.
  function automatic int stage_at(input int b);
    int s;
    s = 0;
    for (int k = 1; k < PIPE; k++)
      if ((2*k*L + PIPE) / (2*PIPE) - 1 == b) s = k;
    return s;
  endfunction

  function automatic lvl_t pre_proc(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic cin, input logic sub);
    lvl_t r;
    logic [WIDTH-1:0] ye;
    ye    = sub ? ~y : y;
    r.c0  = sub | cin;
    r.p   = x ^ ye;
    r.pg  = r.p;
    r.g   = x & ye;
    r.g[0]  = r.g[0] | (r.p[0] & r.c0);
    r.pg[0] = 1'b0;
    return r;
  endfunction

  // One Sklansky level: bits in the upper half of each 2^j block absorb the
  // group from the top bit of the lower half.
  function automatic lvl_t sk_level(input lvl_t a, input int j);
    lvl_t r;
    int   t;
    r = a;
    for (int i = 0; i < WIDTH; i++) begin
      if (((i >> (j-1)) & 1) == 1) begin
        t = ((i >> (j-1)) << (j-1)) - 1;
        r.g[i]  = a.g[i] | (a.pg[i] & a.g[t]);
        r.pg[i] = a.pg[i] & a.pg[t];
      end
    end
    return r;
  endfunction

  logic [PIPE:1] vld_pipe;
  logic [PIPE:1] adv;
  logic [PIPE:1] vsrc;

  // Ready chain from the output back to the input, and each stage's valid source
  always_comb begin
    adv  = '1;
    vsrc = '0;
    adv[PIPE] = ~vld_pipe[PIPE] | out_ready;
    for (int k = PIPE-1; k >= 1; k--) adv[k] = ~vld_pipe[k] | adv[k+1];
    vsrc[1] = in_valid;
    for (int k = 2; k <= PIPE; k++) vsrc[k] = vld_pipe[k-1];
  end

  assign in_ready  = adv[1];
  assign out_valid = vld_pipe[PIPE];

  // Valid shift register; each bit moves only when its stage advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else
      for (int k = 1; k <= PIPE; k++)
        if (adv[k]) vld_pipe[k] <= vsrc[k];
  end

  lvl_t c_out [LOG+1];
  lvl_t q     [LOG+1];

  for (genvar b = 0; b <= LOG; b++) begin : g_lvl
    if (b == 0) begin : g_pre
      assign c_out[0] = pre_proc(in_x, in_y, in_cin, in_sub);
    end else begin : g_sk
      assign c_out[b] = sk_level(q[b-1], b);
    end
    if (stage_at(b) != 0) begin : g_reg
      localparam int K = stage_at(b);
      lvl_t r;
      // Inner stage data register, loads only when the stage advances
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r <= '0;
        else if (adv[K]) r <= c_out[b];
      end
      assign q[b] = r;
    end else begin : g_wire
      assign q[b] = c_out[b];
    end
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  // Final sum and flags from the fully resolved carries
  always_comb begin
    carry = {q[LOG].g, q[LOG].c0};
    sum_c = q[LOG].p ^ carry[WIDTH-1:0];
  end

  // Output stage: registered result, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (adv[PIPE]) begin
      out_sum  <= sum_c;
      out_cout <= carry[WIDTH];
      out_ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
      out_zero <= ~|sum_c;
    end
  end
endmodule
